pipelined_subtractor: RTL and testbench
=======================================

Name: pipelined_subtractor

Overview:
- Two-stage pipelined L-bit subtractor; the inverse datapath of the team's split fast adder.
- Low K bits resolve in stage 1 and produce a registered borrow. High M bits consume that borrow in stage 2.
- Valid/ready on both sides, so it drops into the arithmetic datapath between a producer and a consumer at full throughput.
- Provides unsigned borrow-out and a signed-overflow flag.

Parameters:
- L, 16, total operand width
- M, 8, width of upper segment (stage 2); K = L-M is the lower segment width (stage 1). Legal range: 1 <= M < L.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept a beat this cycle
- A  in  L  minuend
- B  in  L  subtrahend
- Bin  in  1  borrow in
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result this cycle
- diff  out  L  (A - B - Bin) mod 2^L
- Bout  out  1  unsigned borrow out: 1 iff A < B + Bin
- ovf  out  1  signed overflow of A - B - Bin

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: all valid flags 0, so out_valid = 0. diff, Bout, ovf and all data registers are 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation: in-flight beats are discarded, not completed. Inputs presented in the reset cycle are ignored.
- Stage 1 register contents:
  - s1_valid
  - low diff = A[K-1:0] - B[K-1:0] - Bin (K bits)
  - internal borrow bk
  - A[L-1:K], B[L-1:K]
  - sign bits A[L-1], B[L-1]
- Stage 2 register contents:
  - s2_valid
  - full diff = {A_hi - B_hi - bk, low diff}
  - Bout = borrow out of the upper segment
  - ovf = (A[L-1] != B[L-1]) && (diff[L-1] != A[L-1])
- Handshake:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1, combinational from registered state and out_ready only; no path from in_valid.
  - Transfer at input: in_valid && in_ready. Transfer at output: out_valid && out_ready.
- Stage advance:
  - Stage 1 loads when adv1; s1_valid takes in_valid.
  - Stage 2 loads when adv2; s2_valid takes s1_valid.
  - A bubble loads only a valid = 0. Data registers may update or hold; they are don't-care when the valid flag is 0.
- Latency: exactly 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Stall: while out_valid && !out_ready, diff/Bout/ovf are held stable.
  - Stage 1 keeps accepting while it is empty.
  - Once both stages are full, in_ready = 0.
  - No beat is lost or duplicated; order is preserved.
- Simultaneous output pop and input push with both stages full: everything shifts in one cycle and in_ready stays 1.
- Wrap-around: the arithmetic is modulo 2^L with no saturation.
- Borrow chaining: bk equals the borrow out of the low K bits, including Bin. The upper segment treats bk exactly like a borrow in.

Decomposition:
- Shared package (arith_pkg):
  - defaults L_DEF = 16, M_DEF = 8
  - a function computing signed overflow for subtract, reused by the adder's verification
- One natural sub-module: rsub_segment #(W). Purely combinational W-bit ripple subtract (a, b, bin -> d, bout), instantiated twice (W = K and W = M).
- Pipeline registers and handshake stay in the top module.

Test Plan:
1. Reset release, then A=0x1234, B=0x0034, Bin=0, out_ready=1 -> two cycles later out_valid=1, diff=0x1200, Bout=0, ovf=0.
2. A=0x0100, B=0x0001, Bin=0 (borrow crosses the K boundary) -> diff=0x00FF, Bout=0, ovf=0.
3. A=0x0000, B=0x0001, Bin=0 -> diff=0xFFFF, Bout=1, ovf=0. Then A=0x0000, B=0x0000, Bin=1 -> diff=0xFFFF, Bout=1.
4. A=0x8000, B=0x0000, Bin=1 -> diff=0x7FFF, Bout=0, ovf=1. Then A=0x7FFF, B=0xFFFF, Bin=0 -> diff=0x8000, Bout=1, ovf=1.
5. Back-to-back beats 1..6 (A=n·0x0101, B=n) with out_ready=0 for cycles 2-5:
   - in_ready drops after 2 accepted beats
   - results emerge in order, with values held stable during the stall
   - after release, 1 beat/cycle with no loss
6. Two beats in flight, then rst=1 for one cycle -> out_valid=0 the next cycle, no stale result ever appears, in_ready=1. A fresh beat then completes in 2 cycles.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default widths and the signed-overflow rule
// for subtraction, reused by both the subtractor RTL and adder verification.
package arith_pkg;

  localparam int L_DEF = 16;
  localparam int M_DEF = 8;

  // Overflow when operand signs differ and the result sign departs from the minuend.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/rsub_segment.sv
// Purely combinational W-bit ripple subtractor: d = a - b - bin, bout = borrow out.
module rsub_segment #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] br_s;

  // Bit-serial borrow chain; a bit borrows when a < b + incoming borrow.
  always_comb begin
    br_s    = '0;
    d       = '0;
    br_s[0] = bin;
    for (int i = 0; i < W; i++) begin
      d[i]      = a[i] ^ b[i] ^ br_s[i];
      br_s[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br_s[i]);
    end
    bout = br_s[W];
  end

endmodule

// File: rtl/pipelined_subtractor.sv
// Two-stage valid/ready subtractor: low K bits resolve in stage 1, the upper
// M bits consume the registered borrow in stage 2.
module pipelined_subtractor
  import arith_pkg::*;
#(
  parameter int L = L_DEF,
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [L-1:0] A,
  input  logic [L-1:0] B,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [L-1:0] diff,
  output logic         Bout,
  output logic         ovf
);

  localparam int K = L - M;

  logic         s1_valid_r;
  logic [K-1:0] s1_dlo_r;
  logic         s1_bk_r;
  logic [M-1:0] s1_ahi_r;
  logic [M-1:0] s1_bhi_r;
  logic         s1_asign_r;
  logic         s1_bsign_r;

  logic         s2_valid_r;
  logic [L-1:0] s2_diff_r;
  logic         s2_bout_r;
  logic         s2_ovf_r;

  logic         adv1_s;
  logic         adv2_s;
  logic [K-1:0] lo_d_s;
  logic         lo_b_s;
  logic [M-1:0] hi_d_s;
  logic         hi_b_s;

  rsub_segment #(.W(K)) u_lo (
    .a    (A[K-1:0]),
    .b    (B[K-1:0]),
    .bin  (Bin),
    .d    (lo_d_s),
    .bout (lo_b_s)
  );

  rsub_segment #(.W(M)) u_hi (
    .a    (s1_ahi_r),
    .b    (s1_bhi_r),
    .bin  (s1_bk_r),
    .d    (hi_d_s),
    .bout (hi_b_s)
  );

  // Advance enables depend only on registered state and out_ready, never on in_valid.
  always_comb begin
    adv2_s = !s2_valid_r || out_ready;
    adv1_s = !s1_valid_r || adv2_s;
  end

  // Stage 1: low-segment result, its borrow, and the upper operand halves.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_dlo_r   <= '0;
      s1_bk_r    <= 1'b0;
      s1_ahi_r   <= '0;
      s1_bhi_r   <= '0;
      s1_asign_r <= 1'b0;
      s1_bsign_r <= 1'b0;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      s1_dlo_r   <= lo_d_s;
      s1_bk_r    <= lo_b_s;
      s1_ahi_r   <= A[L-1:K];
      s1_bhi_r   <= B[L-1:K];
      s1_asign_r <= A[L-1];
      s1_bsign_r <= B[L-1];
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: full difference plus flags; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_diff_r  <= '0;
      s2_bout_r  <= 1'b0;
      s2_ovf_r   <= 1'b0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      s2_diff_r  <= {hi_d_s, s1_dlo_r};
      s2_bout_r  <= hi_b_s;
      s2_ovf_r   <= sub_ovf(s1_asign_r, s1_bsign_r, hi_d_s[M-1]);
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign in_ready  = adv1_s;
  assign out_valid = s2_valid_r;
  assign diff      = s2_diff_r;
  assign Bout      = s2_bout_r;
  assign ovf       = s2_ovf_r;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Randomized and directed bench for pipelined_subtractor, scored against an
// arithmetic reference model and an in-order expectation queue.
module tb_pipelined_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        Bout;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          rdy;
  } exp_t;

  exp_t q[$];

  pipelined_subtractor #(.L(16), .M(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .Bout      (Bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference from plain integer arithmetic.
  function automatic exp_t ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bi);
    exp_t e;
    int ua, ub, r, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    r  = ua - ub - int'(bi);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = sa - sb - int'(bi);
    e.d   = r[15:0];
    e.bo  = (ua < ub + int'(bi));
    e.ov  = (sr > 32767) || (sr < -32768);
    e.rdy = 0;
    return e;
  endfunction

  // One clock cycle: drive, check outputs against the model, clock, update model.
  task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic bi, input logic ordy, input logic r, input logic en,
                      output logic acc);
    logic ixfer, oxfer, exp_ov, exp_ir;
    exp_t e;
    rst = r; in_valid = iv; A = a; B = b; Bin = bi; out_ready = ordy;
    #1;
    if (en) begin
      exp_ov = (q.size() > 0) && (cyc >= q[0].rdy);
      exp_ir = !((q.size() >= 2) && !(exp_ov && ordy));
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      if (out_valid && exp_ov) begin
        chk("diff", {16'd0, diff}, {16'd0, q[0].d});
        chk("bout", {31'd0, Bout}, {31'd0, q[0].bo});
        chk("ovf", {31'd0, ovf}, {31'd0, q[0].ov});
      end
    end
    ixfer = iv && in_ready;
    oxfer = out_valid && ordy;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      acc = 1'b0;
    end else begin
      if (oxfer && q.size() > 0) void'(q.pop_front());
      if (ixfer) begin
        e = ref_sub(a, b, bi);
        e.rdy = cyc + 1;
        q.push_back(e);
      end
      acc = ixfer;
    end
    #1;
  endtask

  logic        acc;
  int          n;
  logic [15:0] ra, rb;

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = 16'h0; B = 16'h0; Bin = 1'b0; out_ready = 1'b1;
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    step(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    #1;
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, Bout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Directed vectors from the plan, back-to-back at full throughput.
    step(1'b1, 16'h1234, 16'h0034, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, acc);

    // Beats 1..6 with the consumer stalled for cycles 2-5.
    n = 1;
    for (int c = 1; c <= 14; c++) begin
      logic [15:0] av;
      av = 16'(n * 16'h0101);
      step(n <= 6, av, 16'(n), 1'b0, !(c >= 2 && c <= 5), 1'b0, 1'b1, acc);
      if (acc) n++;
    end
    chk("stall_all_accepted", n, 7);

    // Two beats in flight, then reset discards them.
    step(1'b1, 16'h4444, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 16'h5555, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 16'h6666, 16'h3333, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    step(1'b1, 16'h0F00, 16'h00F0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, acc);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 7 == 0) rb = ra;
      step(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), 1'($urandom_range(0, 9) < 7),
           1'(i == 200), 1'b1, acc);
    end

    // Drain with a bounded budget.
    for (int i = 0; i < 20 && q.size() > 0; i++)
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    chk("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
